// File: rtl/rename_map_stage.sv
// rename_map_stage: two-wide register rename between decode and dispatch.
// Keeps a speculative RAT (updated as groups are renamed) and an architectural
// RAT (updated on commit); rollback copies the architectural map back over the
// speculative one. Optional build macro RENAME_STALL_CNT_EN adds a stall counter.
//
// Handshake: a group transfers on the input side when in_ready is high in the
// same cycle as any in_valid bit; the registered output group transfers when
// out_valid is non-zero and out_ready is high.

`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE     2'd0
`endif
`ifndef ROB_STATE_ROLLBACK
`define ROB_STATE_ROLLBACK 2'd1
`endif
`ifndef ROB_STATE_WALK
`define ROB_STATE_WALK     2'd2
`endif

module rename_map_stage #(
    parameter int ARCH_REGS = 32,
    parameter int PREG_W    = 6,
    localparam int AREG_W   = $clog2(ARCH_REGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        in_valid,
    output logic              in_ready,
    input  logic [AREG_W-1:0] in0_rs1,
    input  logic [AREG_W-1:0] in0_rs2,
    input  logic [AREG_W-1:0] in0_rd,
    input  logic              in0_wen,
    input  logic [AREG_W-1:0] in1_rs1,
    input  logic [AREG_W-1:0] in1_rs2,
    input  logic [AREG_W-1:0] in1_rd,
    input  logic              in1_wen,
    output logic              req0_valid,
    output logic              req1_valid,
    input  logic [PREG_W-1:0] req0_data,
    input  logic [PREG_W-1:0] req1_data,
    input  logic              freelist_can_alloc,
    output logic [1:0]        out_valid,
    input  logic              out_ready,
    output logic [PREG_W-1:0] out0_prs1,
    output logic [PREG_W-1:0] out0_prs2,
    output logic [PREG_W-1:0] out0_prd,
    output logic [PREG_W-1:0] out0_old_prd,
    output logic [PREG_W-1:0] out1_prs1,
    output logic [PREG_W-1:0] out1_prs2,
    output logic [PREG_W-1:0] out1_prd,
    output logic [PREG_W-1:0] out1_old_prd,
    input  logic              commit0_valid,
    input  logic              commit1_valid,
    input  logic [AREG_W-1:0] commit0_rd,
    input  logic [AREG_W-1:0] commit1_rd,
    input  logic [PREG_W-1:0] commit0_prd,
    input  logic [PREG_W-1:0] commit1_prd,
    input  logic [PREG_W-1:0] commit0_old_prd,
    input  logic [PREG_W-1:0] commit1_old_prd,
    output logic              write0_valid,
    output logic [PREG_W-1:0] write0_data,
    output logic              write1_valid,
    output logic [PREG_W-1:0] write1_data,
    input  logic [1:0]        rob_state
`ifdef RENAME_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic [PREG_W-1:0] spec_rat [ARCH_REGS];
    logic [PREG_W-1:0] arch_rat [ARCH_REGS];
    logic [PREG_W-1:0] arch_next [ARCH_REGS];

    logic is_idle, is_rollback, fire, need0, need1;
    logic [PREG_W-1:0] new0, new1, old0, old1;
    logic [PREG_W-1:0] prs0_1, prs0_2, prs1_1, prs1_2;

    // Handshake, allocation requests and freelist return ports
    always_comb begin
        is_idle      = (rob_state == `ROB_STATE_IDLE);
        is_rollback  = (rob_state == `ROB_STATE_ROLLBACK);
        in_ready     = is_idle & (~|out_valid | out_ready) & freelist_can_alloc;
        fire         = (|in_valid) & in_ready;
        // x0 never allocates, so its map entry stays at tag 0 forever
        need0        = in_valid[0] & in0_wen & (in0_rd != '0);
        need1        = in_valid[1] & in1_wen & (in1_rd != '0);
        req0_valid   = fire & (need0 | need1);
        req1_valid   = fire & need0 & need1;
        write0_valid = commit0_valid & (commit0_rd != '0);
        write0_data  = commit0_old_prd;
        write1_valid = commit1_valid & (commit1_rd != '0);
        write1_data  = commit1_old_prd;
    end

    // Tag lookup with slot0 -> slot1 bypass inside the group
    always_comb begin
        new0   = need0 ? req0_data : '0;
        new1   = '0;
        if (need1) new1 = need0 ? req1_data : req0_data;
        old0   = need0 ? spec_rat[in0_rd] : '0;
        old1   = '0;
        if (need1) old1 = (need0 && in1_rd == in0_rd) ? new0 : spec_rat[in1_rd];
        prs0_1 = spec_rat[in0_rs1];
        prs0_2 = spec_rat[in0_rs2];
        prs1_1 = (need0 && in1_rs1 == in0_rd) ? new0 : spec_rat[in1_rs1];
        prs1_2 = (need0 && in1_rs2 == in0_rd) ? new0 : spec_rat[in1_rs2];
    end

    // Architectural map after this cycle's commits; commit1 wins on equal rd
    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) arch_next[i] = arch_rat[i];
        if (write0_valid) arch_next[commit0_rd] = commit0_prd;
        if (write1_valid) arch_next[commit1_rd] = commit1_prd;
    end

    // Architectural RAT update
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ARCH_REGS; i++) arch_rat[i] <= PREG_W'(i);
        end else begin
            for (int i = 0; i < ARCH_REGS; i++) arch_rat[i] <= arch_next[i];
        end
    end

    // Speculative RAT: rollback restore, else rename writes (slot1 last)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ARCH_REGS; i++) spec_rat[i] <= PREG_W'(i);
        end else if (is_rollback) begin
            for (int i = 0; i < ARCH_REGS; i++) spec_rat[i] <= arch_next[i];
        end else if (fire) begin
            if (need0) spec_rat[in0_rd] <= new0;
            if (need1) spec_rat[in1_rd] <= new1;
        end
    end

    // Output group register; walk holds it, rollback flushes it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= '0;
            out0_prs1    <= '0;
            out0_prs2    <= '0;
            out0_prd     <= '0;
            out0_old_prd <= '0;
            out1_prs1    <= '0;
            out1_prs2    <= '0;
            out1_prd     <= '0;
            out1_old_prd <= '0;
        end else if (is_rollback) begin
            out_valid <= '0;
        end else if (fire) begin
            out_valid    <= in_valid;
            out0_prs1    <= prs0_1;
            out0_prs2    <= prs0_2;
            out0_prd     <= new0;
            out0_old_prd <= old0;
            out1_prs1    <= prs1_1;
            out1_prs2    <= prs1_2;
            out1_prd     <= new1;
            out1_old_prd <= old1;
        end else if (is_idle && out_ready) begin
            out_valid <= '0;
        end
    end

`ifdef RENAME_STALL_CNT_EN
    // Count cycles where decode offers a group that is not accepted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (is_rollback) begin
            stall_cnt <= '0;
        end else if ((|in_valid) & ~in_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/rename_map_stage.md
Name: rename_map_stage

Overview:
- Two-wide register-rename stage sitting between decode and dispatch/ROB enqueue.
- Consumes physical registers from the freelist via its req0/req1 ports and maintains a speculative RAT plus an architectural (commit) RAT.
- On commit, returns old physical registers to the freelist write ports.
- On ROB rollback, restores the speculative RAT from the architectural RAT.

Parameters:
ARCH_REGS, 32, number of architectural integer registers (index width 5)
PREG_W, 6, physical register tag width (matches `PREG_RANGE)

Ports:
clock  in  1  core clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  2  per-slot decoded instruction valid (bit0 = older)
in_ready  out  1  stage accepts the group this cycle
in0_rs1/in0_rs2/in0_rd  in  5 each  slot0 architectural sources/destination
in0_wen  in  1  slot0 writes rd
in1_rs1/in1_rs2/in1_rd/in1_wen  in  5/5/5/1  slot1 equivalents
req0_valid/req1_valid  out  1 each  freelist allocation requests
req0_data/req1_data  in  PREG_W each  freelist-returned tags (same cycle)
freelist_can_alloc  in  1  freelist has free entries
out_valid  out  2  registered renamed group valid
out_ready  in  1  downstream accepts group
out0_prs1/out0_prs2/out0_prd/out0_old_prd  out  PREG_W each  slot0 renamed tags
out1_prs1/out1_prs2/out1_prd/out1_old_prd  out  PREG_W each  slot1 renamed tags
commit0_valid/commit1_valid  in  1 each  ROB commit slot valid
commit0_rd/commit1_rd  in  5 each  committed architectural destination
commit0_prd/commit1_prd  in  PREG_W each  committed new tag
commit0_old_prd/commit1_old_prd  in  PREG_W each  tag to free
write0_valid/write0_data, write1_valid/write1_data  out  1/PREG_W  freelist free ports
rob_state  in  2  `ROB_STATE_IDLE / `ROB_STATE_ROLLBACK / `ROB_STATE_WALK

Behaviour:
- Reset:
  - spec_rat[i] = i and arch_rat[i] = i for all i.
  - out_valid = 0; all out* tags = 0.
- need_k = in_valid[k] & ink_wen & (ink_rd != 0). Register x0 never allocates and always maps to tag 0.
- in_ready = is_idle & (~|out_valid | out_ready) & freelist_can_alloc.
- fire = (|in_valid) & in_ready.
- Request compaction:
  - req0_valid = fire & (need0 | need1).
  - req1_valid = fire & need0 & need1.
  - The first needing slot takes req0_data; the second takes req1_data.
- Source lookup is combinational from spec_rat, with intra-group bypass:
  - If need0 and in1_rsX == in0_rd, then out1_prsX = slot0's new tag.
  - If need0 and in1_rd == in0_rd, then slot1 old_prd = slot0's new tag.
- Non-writing slot: prd = 0, old_prd = 0.
- On fire, the output register loads all tags and out_valid = in_valid, visible next cycle (1-cycle latency).
- spec_rat is written on fire: slot0 first, then slot1. Slot1 wins on equal rd.
- Without fire: if out_ready, out_valid is cleared; otherwise the output holds stable.
- Commit path (combinational to freelist):
  - writeK_valid = commitK_valid & (commitK_rd != 0).
  - writeK_data = commitK_old_prd.
  - arch_rat[commitK_rd] <= commitK_prd on the clock edge; commit1 wins on equal rd.
  - Commits are processed in every rob_state.
- Rollback (rob_state == ROLLBACK):
  - spec_rat <= arch_rat next-state value, including same-cycle commits.
  - out_valid <= 0.
  - No fire is possible, since in_ready = 0.
- Walk: in_ready = 0 and no allocation; spec_rat and the output register hold; out_valid is not cleared by walk.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro RENAME_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], reset 0.
  - Increments (wrapping) each cycle with |in_valid & ~in_ready.
  - Cleared on rollback.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then in_valid=2'b11: add x1←x2,x3 and add x4←x1,x5; freelist gives 32,33 -> next cycle out0 prs=2,3 prd=32 old=1; out1 prs1=32 prs2=5 prd=33 old=4; req0/req1 both high.
- Slot0 rd=x0, slot1 rd=x7, freelist req0_data=40 -> req0_valid=1, req1_valid=0; out1_prd=40, out0_prd=0; spec_rat[7]=40.
- Both slots rd=x9, tags 34,35 -> out1_old_prd=34; subsequent read of x9 returns 35.
- out_ready=0 with out_valid set, new group presented -> in_ready=0, outputs stable, no req*_valid; release out_ready -> group accepted the following cycle.
- Commit x1/prd 32/old 1 while rob_state=ROLLBACK after speculative x1→50 -> write0_valid=1 data=1; next cycle read of x1 yields 32 and out_valid=0.
- freelist_can_alloc=0 or rob_state=WALK -> in_ready=0 and req*_valid=0 for the whole duration.
